// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types for the serial adder/subtractor.
//   state_e : FSM state encoding (Idle = 0, Run = 1, Done = 2).
package serial_adder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/fulladder.sv
// fulladder: existing 1-bit full adder cell.
//   x, y : addend bits
//   z    : carry in
//   s    : sum bit
//   c    : carry out
module fulladder (
   output logic s,
   output logic c,
   input  logic x,
   input  logic y,
   input  logic z
);

   assign s = x ^ y ^ z;
   assign c = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor, CHUNK bits per clock, LSB first.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   start    : request, accepted in Idle or Done
//   sub      : 0 = a + b, 1 = a - b (captured with operands)
//   a, b     : operands, captured on accepted start
//   busy     : high while in Run
//   done     : one-cycle pulse when the result is valid
//   sum      : result, held from done until the next accepted start
//   cout     : carry out of the MSB (for subtraction 1 = no borrow)
//   overflow : two's-complement overflow
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder: WIDTH must be >= 2");
   end
   if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("serial_adder: CHUNK must divide WIDTH exactly");
   end

   localparam int unsigned K    = WIDTH / CHUNK;
   // One extra bit so K = 1 still gets a legal counter width.
   localparam int unsigned CntW = $clog2(K) + 1;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              carry_q, carry_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;

   // Ripple chain over the low CHUNK bits of the operand shifters.
   logic [CHUNK:0]    chain_c;
   logic [CHUNK-1:0]  chunk_s;

   assign chain_c[0] = carry_q;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      fulladder u_fa (
         .s (chunk_s[i]),
         .c (chain_c[i+1]),
         .x (a_q[i]),
         .y (b_q[i]),
         .z (chain_c[i])
      );
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StRun;
               a_d     = a;
               // Subtraction as a + ~b + 1: invert b and seed the carry.
               b_d     = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            // Chunk result enters from the MSB side; after K chunks it sits LSB-aligned.
            sum_d   = WIDTH'({chunk_s, sum_q} >> CHUNK);
            carry_d = chain_c[CHUNK];
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntW'(K - 1)) begin
               state_d = StDone;
               cout_d  = chain_c[CHUNK];
               // chain_c[CHUNK-1] is the carry into bit WIDTH-1 on the last chunk.
               ovf_d   = chain_c[CHUNK] ^ chain_c[CHUNK-1];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = (state_q == StRun);
   assign done     = (state_q == StDone);
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule
